// File: rtl/adv7393_frame_reader.sv
// adv7393_frame_reader
//   AXI4 read-master DMA stage. Fetches one video frame line by line from memory
//   and emits it as a word stream with line (m_tlast) and frame (m_tuser) tags.
//   Bursts are split at MAX_BURST beats, at line ends and at 4 KB boundaries, and
//   are only issued once the beat FIFO is guaranteed room for the whole burst.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   cfg_*                frame geometry, captured on an accepted frame_start
//   frame_start          single-cycle fetch request (ignored while busy)
//   busy, frame_done     frame in progress / one-cycle end-of-frame pulse
//   m_axi_ar*, m_axi_r*  AXI4 read address and read data channels
//   m_t*                 pixel-word stream (valid/ready, tlast per line, tuser per frame)
//
// Optional feature (macro ADV7393_RD_ERR_CNT_EN)
//   Adds rd_err_cnt (saturating count of R beats with rresp != OKAY) and the
//   sticky rd_err flag, cleared by reset or by an accepted frame_start.

module adv7393_frame_reader #(
    parameter int unsigned M_AXI_AWIDTH = 32,
    parameter int unsigned M_AXI_DWIDTH = 64,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned FIFO_DEPTH   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [M_AXI_AWIDTH-1:0] cfg_base_addr,
    input  logic [15:0]             cfg_stride,
    input  logic [11:0]             cfg_line_beats,
    input  logic [11:0]             cfg_lines,
    input  logic                    frame_start,
    output logic                    busy,
    output logic                    frame_done,
`ifdef ADV7393_RD_ERR_CNT_EN
    output logic [15:0]             rd_err_cnt,
    output logic                    rd_err,
`endif
    output logic [M_AXI_AWIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arregion,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [M_AXI_DWIDTH-1:0] m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [M_AXI_DWIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser
);

    localparam int unsigned BYTES = M_AXI_DWIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned BW    = $clog2(MAX_BURST) + 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    // FIFO entry: {frame_last, tuser, tlast, data}
    localparam int unsigned EW    = M_AXI_DWIDTH + 3;

    typedef enum logic [2:0] {StIdle, StCalc, StCredit, StAddr, StDrain} state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic [M_AXI_AWIDTH-1:0] line_addr_q, cur_addr_q;
    logic [15:0]             stride_q;
    logic [11:0]             line_beats_q, lines_q;
    logic [11:0]             rem_beats_q, lines_left_q;
    logic [BW-1:0]           burst_q, burst_calc;
    logic [7:0]              arlen_q;
    logic [CW-1:0]           outstanding_q;
    logic [CW-1:0]           wr_ptr_q, rd_ptr_q, fifo_count;
    logic [11:0]             wr_beat_q, wr_line_q;
    logic                    flast_seen_q;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] rd_entry;

    logic ar_hs, r_hs, pop, line_end, credit_ok, start_ok;
    logic w_tlast, w_tuser, w_flast;
    logic [12:0] to_4k, beats_4k, burst_min;
    logic [CW:0] free_beats;
    logic [M_AXI_AWIDTH-1:0] stride_ext, burst_bytes;

    assign start_ok    = (state_q == StIdle) && frame_start;
    assign ar_hs       = (state_q == StAddr) && m_axi_arready;
    assign r_hs        = m_axi_rvalid && busy_q;
    assign fifo_count  = wr_ptr_q - rd_ptr_q;
    assign m_tvalid    = (fifo_count != '0);
    assign pop         = m_tvalid && m_tready;
    assign line_end    = (rem_beats_q == 12'(burst_q));
    assign stride_ext  = M_AXI_AWIDTH'(stride_q);
    assign burst_bytes = M_AXI_AWIDTH'(burst_q) << SIZE;

    // Credit counts both buffered and in-flight beats, so an issued burst can
    // never overrun the FIFO and rready can stay high for the whole frame.
    assign free_beats = (CW+1)'(FIFO_DEPTH) - (CW+1)'(fifo_count) - (CW+1)'(outstanding_q);
    assign credit_ok  = (free_beats >= (CW+1)'(burst_q));

    always_comb begin
        to_4k     = 13'h1000 - {1'b0, cur_addr_q[11:0]};
        beats_4k  = to_4k >> SIZE;
        burst_min = {1'b0, rem_beats_q};
        if (burst_min > 13'(MAX_BURST)) burst_min = 13'(MAX_BURST);
        if (burst_min > beats_4k)       burst_min = beats_4k;
        burst_calc = BW'(burst_min);
    end

    // Write-side framing: tags are computed as beats arrive and stored with them.
    assign w_tlast = (wr_beat_q == line_beats_q - 12'd1);
    assign w_tuser = (wr_beat_q == 12'd0) && (wr_line_q == 12'd0);
    assign w_flast = w_tlast && (wr_line_q == lines_q - 12'd1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    if (cfg_line_beats == 12'd0 || cfg_lines == 12'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                        busy_d  = 1'b1;
                    end
                end
            end
            StCalc:   state_d = StCredit;
            StCredit: if (credit_ok) state_d = StAddr;
            StAddr: begin
                if (m_axi_arready) begin
                    if (!line_end || lines_left_q != 12'd1) state_d = StCalc;
                    else                                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (flast_seen_q || (pop && rd_entry[EW-1])) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_addr_q   <= '0;
            cur_addr_q    <= '0;
            stride_q      <= '0;
            line_beats_q  <= '0;
            lines_q       <= '0;
            rem_beats_q   <= '0;
            lines_left_q  <= '0;
            burst_q       <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_beat_q     <= '0;
            wr_line_q     <= '0;
            flast_seen_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                stride_q     <= cfg_stride;
                line_beats_q <= cfg_line_beats;
                lines_q      <= cfg_lines;
                line_addr_q  <= cfg_base_addr;
                cur_addr_q   <= cfg_base_addr;
                rem_beats_q  <= cfg_line_beats;
                lines_left_q <= cfg_lines;
                wr_beat_q    <= '0;
                wr_line_q    <= '0;
                flast_seen_q <= 1'b0;
            end
            if (state_q == StCalc) begin
                burst_q <= burst_calc;
                arlen_q <= 8'(burst_calc - 1'b1);
            end
            if (ar_hs) begin
                if (line_end) begin
                    line_addr_q  <= line_addr_q + stride_ext;
                    cur_addr_q   <= line_addr_q + stride_ext;
                    rem_beats_q  <= line_beats_q;
                    lines_left_q <= lines_left_q - 12'd1;
                end else begin
                    cur_addr_q  <= cur_addr_q + burst_bytes;
                    rem_beats_q <= rem_beats_q - 12'(burst_q);
                end
            end
            outstanding_q <= outstanding_q + (ar_hs ? CW'(burst_q) : CW'(0))
                                           - (r_hs ? CW'(1) : CW'(0));
            if (r_hs) begin
                wr_ptr_q <= wr_ptr_q + CW'(1);
                if (w_tlast) begin
                    wr_beat_q <= '0;
                    wr_line_q <= wr_line_q + 12'd1;
                end else begin
                    wr_beat_q <= wr_beat_q + 12'd1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + CW'(1);
                if (rd_entry[EW-1]) flast_seen_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (r_hs) mem[wr_ptr_q[PW-1:0]] <= {w_flast, w_tuser, w_tlast, m_axi_rdata};
    end

    assign rd_entry = mem[rd_ptr_q[PW-1:0]];

    assign m_tdata  = m_tvalid ? rd_entry[M_AXI_DWIDTH-1:0] : '0;
    assign m_tlast  = m_tvalid & rd_entry[M_AXI_DWIDTH];
    assign m_tuser  = m_tvalid & rd_entry[M_AXI_DWIDTH+1];

    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign m_axi_araddr   = cur_addr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arregion = 4'b0000;
    assign m_axi_arqos    = 4'b0000;
    assign m_axi_arvalid  = (state_q == StAddr);
    assign m_axi_rready   = busy_q;

`ifdef ADV7393_RD_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (start_ok) err_q <= 1'b0;
            if (r_hs && m_axi_rresp != 2'b00) begin
                err_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign rd_err_cnt = err_cnt_q;
    assign rd_err     = err_q;

    logic unused_rlast;
    assign unused_rlast = m_axi_rlast;
`else
    logic unused_rsp;
    assign unused_rsp = ^{m_axi_rlast, m_axi_rresp};
`endif

endmodule

// File: tb/tb_adv7393_frame_reader.sv
`timescale 1ns/1ps
module tb_adv7393_frame_reader;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [15:0] cfg_stride = '0;
    logic [11:0] cfg_line_beats = '0;
    logic [11:0] cfg_lines = '0;
    logic        frame_start = 1'b0;
    logic        busy, frame_done;
`ifdef ADV7393_RD_ERR_CNT_EN
    logic [15:0] rd_err_cnt;
    logic        rd_err;
`endif
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arregion;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;

    always #5 clk = ~clk;

    adv7393_frame_reader dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_stride     (cfg_stride),
        .cfg_line_beats (cfg_line_beats),
        .cfg_lines      (cfg_lines),
        .frame_start    (frame_start),
        .busy           (busy),
        .frame_done     (frame_done),
`ifdef ADV7393_RD_ERR_CNT_EN
        .rd_err_cnt     (rd_err_cnt),
        .rd_err         (rd_err),
`endif
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arlock   (m_axi_arlock),
        .m_axi_arcache  (m_axi_arcache),
        .m_axi_arprot   (m_axi_arprot),
        .m_axi_arregion (m_axi_arregion),
        .m_axi_arqos    (m_axi_arqos),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser)
    );

    typedef struct packed {logic [63:0] data; logic last; logic user;} word_t;
    typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct packed {logic [31:0] addr; logic last;} beat_t;

    word_t exp_words[$];
    ar_t   exp_ars[$];
    beat_t r_beats[$];

    int errors = 0, checks = 0;
    int ar_cnt = 0, ar_beat_total = 0, word_cnt = 0, done_cnt = 0;
    int tready_mode = 1, arready_mode = 1, rvalid_rand = 0, err_beats = 0;
    bit r_hs_s = 0, ar_stall = 0, t_stall = 0;
    ar_t   ar_prev, ea;
    word_t t_prev, ew, got_w;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // ---------------- monitor: samples handshakes on the falling edge ----------
    initial begin
        forever begin
            @(negedge clk);
            r_hs_s = 0;
            if (!reset) begin
                ar_stall = 0;
                t_stall  = 0;
            end else begin
                if (ar_stall) begin
                    checks++;
                    if (!m_axi_arvalid || m_axi_araddr !== ar_prev.addr || m_axi_arlen !== ar_prev.len) begin
                        errors++;
                        $display("FAIL ar_hold got v=%b addr=%h len=%0d exp addr=%h len=%0d",
                                 m_axi_arvalid, m_axi_araddr, m_axi_arlen, ar_prev.addr, ar_prev.len);
                    end
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_cnt++;
                    ar_beat_total += int'(m_axi_arlen) + 1;
                    checks++;
                    if (exp_ars.size() == 0) begin
                        errors++;
                        $display("FAIL ar_unexpected got addr=%h len=%0d exp none", m_axi_araddr, m_axi_arlen);
                    end else begin
                        ea = exp_ars.pop_front();
                        if (m_axi_araddr !== ea.addr || m_axi_arlen !== ea.len) begin
                            errors++;
                            $display("FAIL ar got addr=%h len=%0d exp addr=%h len=%0d",
                                     m_axi_araddr, m_axi_arlen, ea.addr, ea.len);
                        end
                    end
                    for (int i = 0; i <= int'(m_axi_arlen); i++) begin
                        beat_t b;
                        b.addr = m_axi_araddr + 32'(i * 8);
                        b.last = (i == int'(m_axi_arlen));
                        r_beats.push_back(b);
                    end
                end
                ar_stall = m_axi_arvalid && !m_axi_arready;
                ar_prev.addr = m_axi_araddr;
                ar_prev.len  = m_axi_arlen;
                if (m_axi_rvalid && m_axi_rready) r_hs_s = 1;
                got_w.data = m_tdata;
                got_w.last = m_tlast;
                got_w.user = m_tuser;
                if (t_stall) begin
                    checks++;
                    if (!m_tvalid || got_w !== t_prev) begin
                        errors++;
                        $display("FAIL t_hold got v=%b word=%h exp word=%h", m_tvalid, got_w, t_prev);
                    end
                end
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (exp_words.size() == 0) begin
                        errors++;
                        $display("FAIL word_unexpected got data=%h exp none", m_tdata);
                    end else begin
                        ew = exp_words.pop_front();
                        if (got_w !== ew) begin
                            errors++;
                            $display("FAIL word%0d got data=%h last=%b user=%b exp data=%h last=%b user=%b",
                                     word_cnt, m_tdata, m_tlast, m_tuser, ew.data, ew.last, ew.user);
                        end
                    end
                    word_cnt++;
                end
                t_stall = m_tvalid && !m_tready;
                t_prev  = got_w;
                if (frame_done) done_cnt++;
            end
        end
    end

    // ---------------- AXI slave / stream sink driver ---------------------------
    initial begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 0; m_tready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                r_beats.delete();
                m_axi_rvalid = 0;
            end else begin
                if (r_hs_s) begin
                    void'(r_beats.pop_front());
                    m_axi_rvalid = 0;
                    if (err_beats > 0) err_beats--;
                end
                if (!m_axi_rvalid && r_beats.size() > 0 &&
                    (rvalid_rand == 0 || $urandom_range(3) != 0)) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem_word(r_beats[0].addr);
                    m_axi_rlast  = r_beats[0].last;
                    m_axi_rresp  = (err_beats > 0) ? 2'b10 : 2'b00;
                end
            end
            m_axi_arready = (arready_mode == 2) ? 1'($urandom_range(1)) : 1'(arready_mode);
            m_tready      = (tready_mode == 2)  ? 1'($urandom_range(1)) : 1'(tready_mode);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ------------------------------------------
    task automatic push_words(input logic [31:0] base, input int stride, input int lb, input int lines);
        for (int l = 0; l < lines; l++)
            for (int b = 0; b < lb; b++) begin
                word_t w;
                w.data = mem_word(base + 32'(l * stride) + 32'(b * 8));
                w.last = (b == lb - 1);
                w.user = (l == 0 && b == 0);
                exp_words.push_back(w);
            end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] len);
        ar_t e;
        e.addr = a;
        e.len  = len;
        exp_ars.push_back(e);
    endtask

    task automatic push_ars_model(input logic [31:0] base, input int stride, input int lb, input int lines);
        for (int l = 0; l < lines; l++) begin
            logic [31:0] a;
            int rem, n, b4k;
            a = base + 32'(l * stride);
            rem = lb;
            while (rem > 0) begin
                b4k = (4096 - int'(a & 32'hFFF)) / 8;
                n = rem;
                if (n > MAXB) n = MAXB;
                if (n > b4k) n = b4k;
                push_ar(a, 8'(n - 1));
                a = a + 32'(n * 8);
                rem -= n;
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input int stride, input int lb, input int lines);
        @(posedge clk);
        #1;
        cfg_base_addr  = base;
        cfg_stride     = 16'(stride);
        cfg_line_beats = 12'(lb);
        cfg_lines      = 12'(lines);
        frame_start    = 1;
        @(posedge clk);
        #1;
        frame_start = 0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- tests -----------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, frame_done, m_axi_arvalid, m_axi_rready, m_tvalid, m_tlast, m_tuser, m_axi_arlock} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000000",
                     {busy, frame_done, m_axi_arvalid, m_axi_rready, m_tvalid, m_tlast, m_tuser, m_axi_arlock});
        end
        checks++;
        if ({m_axi_araddr, m_axi_arlen, m_tdata} !== 104'b0) begin
            errors++;
            $display("FAIL reset_addr_data got addr=%h len=%0d data=%h exp 0", m_axi_araddr, m_axi_arlen, m_tdata);
        end
        checks++;
        if (m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'b0011) begin
            errors++;
            $display("FAIL reset_const got size=%0d burst=%b cache=%b exp 3 01 0011",
                     m_axi_arsize, m_axi_arburst, m_axi_arcache);
        end
        checks++;
        if ({m_axi_arprot, m_axi_arregion, m_axi_arqos} !== 11'b0) begin
            errors++;
            $display("FAIL reset_attr got %b exp 0", {m_axi_arprot, m_axi_arregion, m_axi_arqos});
        end
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic test_basic();
        int w0, d0;
        bit ok;
        tready_mode = 1; arready_mode = 1; rvalid_rand = 0;
        push_ar(32'h1000, 8'd15);
        push_ar(32'h1080, 8'd3);
        push_ar(32'h1200, 8'd15);
        push_ar(32'h1280, 8'd3);
        push_words(32'h1000, 32'h200, 20, 2);
        w0 = word_cnt;
        d0 = done_cnt;
        start_frame(32'h1000, 32'h200, 20, 2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", busy);
        end
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got timeout exp frame_done");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end got %b exp 0", busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (word_cnt - w0 != 40 || done_cnt - d0 != 1 || exp_ars.size() != 0) begin
            errors++;
            $display("FAIL basic_counts got words=%0d dones=%0d ars_left=%0d exp 40 1 0",
                     word_cnt - w0, done_cnt - d0, exp_ars.size());
        end
    endtask

    task automatic test_4k_split();
        bit ok;
        tready_mode = 2; arready_mode = 2; rvalid_rand = 1;
        push_ar(32'h0FF0, 8'd1);
        push_ar(32'h1000, 8'd5);
        push_words(32'h0FF0, 0, 8, 1);
        start_frame(32'h0FF0, 0, 8, 1);
        wait_done(2000, ok);
        checks++;
        if (!ok || exp_words.size() != 0 || exp_ars.size() != 0) begin
            errors++;
            $display("FAIL split4k got done=%b words_left=%0d ars_left=%0d exp 1 0 0",
                     ok, exp_words.size(), exp_ars.size());
        end
    endtask

    task automatic test_backpressure();
        int b0, w0;
        bit ok;
        tready_mode = 0; arready_mode = 1; rvalid_rand = 1;
        push_ars_model(32'h2000, 0, 200, 1);
        push_words(32'h2000, 0, 200, 1);
        b0 = ar_beat_total;
        w0 = word_cnt;
        start_frame(32'h2000, 0, 200, 1);
        repeat (300) @(posedge clk);
        #2;
        checks++;
        if (ar_beat_total - b0 != 64) begin
            errors++;
            $display("FAIL bp_credit got beats=%0d exp 64", ar_beat_total - b0);
        end
        checks++;
        if (m_tvalid !== 1'b1 || word_cnt != w0) begin
            errors++;
            $display("FAIL bp_stall got tvalid=%b words=%0d exp 1 0", m_tvalid, word_cnt - w0);
        end
        tready_mode = 2;
        wait_done(5000, ok);
        checks++;
        if (!ok || word_cnt - w0 != 200 || exp_words.size() != 0 || exp_ars.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got done=%b words=%0d left=%0d ars_left=%0d exp 1 200 0 0",
                     ok, word_cnt - w0, exp_words.size(), exp_ars.size());
        end
    endtask

    task automatic test_zero_geom();
        int lb_tab[2] = '{5, 0};
        int ln_tab[2] = '{0, 3};
        tready_mode = 1; arready_mode = 1; rvalid_rand = 0;
        for (int k = 0; k < 2; k++) begin
            int a0;
            bit saw_ar;
            a0 = ar_cnt;
            saw_ar = 0;
            start_frame(32'h3000, 32'h100, lb_tab[k], ln_tab[k]);
            checks++;
            if (frame_done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero%0d_done got done=%b busy=%b exp 1 0", k, frame_done, busy);
            end
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (m_axi_arvalid || busy || frame_done) saw_ar = 1;
            end
            checks++;
            if (saw_ar || ar_cnt != a0) begin
                errors++;
                $display("FAIL zero%0d_quiet got activity=%b ars=%0d exp 0 0", k, saw_ar, ar_cnt - a0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0, w0;
        bit ok, hit;
        tready_mode = 1; arready_mode = 1; rvalid_rand = 1;
        push_ars_model(32'h4000, 32'h400, 64, 4);
        push_words(32'h4000, 32'h400, 64, 4);
        a0 = ar_cnt;
        hit = 0;
        start_frame(32'h4000, 32'h400, 64, 4);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (ar_cnt - a0 >= 3) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rmid_ars got %0d exp 3", ar_cnt - a0);
        end
        reset = 0;
        #1;
        checks++;
        if ({busy, frame_done, m_axi_arvalid, m_axi_rready, m_tvalid, m_tlast, m_tuser,
             m_axi_araddr, m_axi_arlen, m_tdata, m_axi_arsize, m_axi_arburst, m_axi_arcache}
            !== {7'b0, 32'h0, 8'h0, 64'h0, 3'd3, 2'b01, 4'b0011}) begin
            errors++;
            $display("FAIL rmid_outputs got busy=%b done=%b arv=%b rr=%b tv=%b addr=%h len=%0d data=%h exp all 0",
                     busy, frame_done, m_axi_arvalid, m_axi_rready, m_tvalid, m_axi_araddr, m_axi_arlen, m_tdata);
        end
        exp_words.delete();
        exp_ars.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        push_ars_model(32'h4000, 32'h400, 64, 4);
        push_words(32'h4000, 32'h400, 64, 4);
        w0 = word_cnt;
        start_frame(32'h4000, 32'h400, 64, 4);
        wait_done(5000, ok);
        checks++;
        if (!ok || word_cnt - w0 != 256 || exp_words.size() != 0 || exp_ars.size() != 0) begin
            errors++;
            $display("FAIL rmid_refetch got done=%b words=%0d left=%0d ars_left=%0d exp 1 256 0 0",
                     ok, word_cnt - w0, exp_words.size(), exp_ars.size());
        end
    endtask

`ifdef ADV7393_RD_ERR_CNT_EN
    task automatic test_err_cnt();
        bit ok;
        tready_mode = 1; arready_mode = 1; rvalid_rand = 0;
        err_beats = 3;
        push_ars_model(32'h5000, 0, 8, 1);
        push_words(32'h5000, 0, 8, 1);
        start_frame(32'h5000, 0, 8, 1);
        wait_done(2000, ok);
        checks++;
        if (!ok || rd_err_cnt !== 16'd3 || rd_err !== 1'b1) begin
            errors++;
            $display("FAIL err_count got done=%b cnt=%0d err=%b exp 1 3 1", ok, rd_err_cnt, rd_err);
        end
        start_frame(32'h5000, 0, 8, 0);
        checks++;
        if (rd_err !== 1'b0 || rd_err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL err_clear got err=%b cnt=%0d exp 0 3", rd_err, rd_err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_4k_split();
        test_backpressure();
        test_zero_geom();
        test_reset_mid();
`ifdef ADV7393_RD_ERR_CNT_EN
        test_err_cnt();
`endif
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adv7393_frame_reader.md
Name: adv7393_frame_reader

Overview:
AXI4 read-master DMA stage that fetches one video frame from memory, line by line, and presents it as a pixel-word stream. It sits directly upstream of the ADV7393 output/timing stage: it consumes frame geometry from the register block and feeds buffered frame data downstream. Per-frame address generation, burst splitting, credit-based flow control and line/frame framing all live here. Clock-domain crossing to clk_pixel is done downstream.

Parameters:
M_AXI_AWIDTH, 32, AXI address width.
M_AXI_DWIDTH, 64, AXI read data width; one stream word per beat.
MAX_BURST, 16, maximum beats per AR burst (power of 2, at most 256).
FIFO_DEPTH, 64, internal beat FIFO depth (power of 2, at least MAX_BURST).

Ports:
clk  in  1  single clock for all logic.
reset  in  1  asynchronous, active-low reset.
cfg_base_addr  in  M_AXI_AWIDTH  frame base byte address, aligned to M_AXI_DWIDTH/8.
cfg_stride  in  16  byte distance between line starts, beat-aligned.
cfg_line_beats  in  12  beats per line.
cfg_lines  in  12  lines per frame.
frame_start  in  1  single-cycle request to fetch one frame.
busy  out  1  high from an accepted frame_start until frame_done.
frame_done  out  1  single-cycle pulse when the last frame word is accepted downstream.
m_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arregion/arqos/arvalid  out  AXI4 widths  read address channel.
m_axi_arready  in  1  read address ready.
m_axi_rdata  in  M_AXI_DWIDTH  read data.
m_axi_rresp/rlast/rvalid  in  2/1/1  read response, last beat, valid.
m_axi_rready  out  1  read data ready.
m_tdata  out  M_AXI_DWIDTH  stream word.
m_tvalid  out  1  stream valid.
m_tready  in  1  stream ready.
m_tlast  out  1  asserted on the last word of each line.
m_tuser  out  1  asserted on the first word of the frame.

Behaviour:
- Reset values: every output is 0, with these exceptions:
  - arsize = log2(M_AXI_DWIDTH/8).
  - arburst = 2'b01 (INCR).
  - arcache = 4'b0011.
  - All of these are constant after reset.
  - Reset flushes the FIFO and all counters.
- Reset mid-frame: the block returns to IDLE at once. Outstanding AXI reads are not tracked; the interconnect shares the same reset.
- FSM IDLE:
  - frame_start latches all cfg_* values and sets busy on the next cycle.
  - frame_start while busy is ignored.
  - If cfg_line_beats==0 or cfg_lines==0: frame_done pulses 1 cycle after frame_start, busy never rises, no AXI traffic.
- FSM CALC: burst = min(line beats remaining, MAX_BURST, beats to next 4 KB boundary). Takes 1 cycle, then goes to CREDIT.
- FSM CREDIT: waits until FIFO_DEPTH - fifo_count - outstanding_beats >= burst, then goes to ADDR.
- FSM ADDR:
  - Drives arvalid with araddr and arlen = burst-1; both are held stable until arready. No combinational path from arready to arvalid.
  - On handshake, outstanding_beats += burst and the address advances by burst*(M_AXI_DWIDTH/8).
  - If the line is not finished, go to CALC.
  - Otherwise the line address advances by cfg_stride. Go to CALC if lines remain, else to DRAIN.
- FSM DRAIN: waits for the final word to be accepted downstream, pulses frame_done, clears busy in the same cycle, returns to IDLE.
- R channel:
  - rready = 1 whenever busy; credit guarantees FIFO space.
  - Each accepted beat enters the FIFO and decrements outstanding_beats. An AR acceptance and R beat in the same cycle net correctly.
  - rlast and rresp do not affect framing; error beats are forwarded unchanged.
- Framing: a beat/line counter on the write side tags m_tlast (beat == cfg_line_beats-1) and m_tuser (first beat of frame). The tags travel through the FIFO with the data.
- Stream: standard valid/ready. m_tvalid = FIFO not empty; data and tags are held stable while m_tvalid && !m_tready. FIFO read latency is 1 cycle from beat accept to m_tvalid.
- Widths: line and burst addresses wrap modulo 2^M_AXI_AWIDTH.

Optional Feature:
ADV7393_RD_ERR_CNT_EN
- Defined:
  - Adds output rd_err_cnt [15:0], counting R beats with rresp != 2'b00. It saturates at 16'hFFFF.
  - Adds sticky output rd_err, cleared only by reset or by an accepted frame_start.
- Undefined: neither port exists and rresp is ignored.

Test Plan:
- Basic fetch: cfg_line_beats=20, cfg_lines=2, base=0x1000, stride=0x200, MAX_BURST=16 -> four ARs: (0x1000,len15), (0x1080,len3), (0x1200,len15), (0x1280,len3); 40 words; m_tlast on words 19 and 39; m_tuser on word 0 only; one frame_done.
- 4 KB split: base=0x0FF0, line_beats=8 -> ARs (0x0FF0,len1) and (0x1000,len5).
- Backpressure: m_tready=0 throughout, FIFO_DEPTH=64, line_beats=200 -> AR bursts stop once 64 beats are fetched or outstanding; no beat is lost when m_tready is then toggled at random; output word order matches memory.
- Zero geometry: cfg_lines=0 then frame_start -> frame_done 1 cycle later, arvalid never asserted.
- Reset mid-frame: assert reset after 3 ARs -> all outputs return to reset values; a subsequent frame_start fetches the full frame correctly.
- Error count (macro defined): rresp=2'b10 on 3 beats -> rd_err_cnt=3, rd_err=1; next frame_start clears rd_err.
